// File: rtl/spi_slave.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : spi_slave
//  Description : SPI mode-0 slave with oversampled inputs. spi_clk,
//                chip_select and spi_mosi are synchronised into clk, edges
//                are found against a delayed copy, and an IDLE/SHIFT/COMPLETE
//                controller shifts DATA_W-bit words MSB first in both
//                directions. A one-word transmit buffer supplies the MISO word.
//                Optional build macro SPI_SLAVE_FRAME_ERR_EN adds a frame_err
//                pulse output for words cut short by chip_select.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              chip_select,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
`ifdef SPI_SLAVE_FRAME_ERR_EN
    output logic              frame_err,
`endif
    output logic              busy
);

    localparam int                  c_CNT_W    = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0]  c_LAST_BIT = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam int                  c_WARM_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [c_WARM_W-1:0] c_WARM_CYC = c_WARM_W'(SYNC_STAGES + 1);
    localparam logic [c_WARM_W-1:0] c_WARM_ONE = c_WARM_W'(1);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_SHIFT    = 2'd1;
    localparam logic [1:0] c_ST_COMPLETE = 2'd2;

    // synchronisers and edge-detect delay taps
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_dly;
    logic                   r_cs_dly;

    // start-up qualification so the reset values of the chain cannot fake an edge
    logic [c_WARM_W-1:0]    r_warm_cnt;
    logic                   r_warm;

    // controller state
    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic [DATA_W-2:0]      r_rx_shift;
    logic [DATA_W-1:0]      r_tx_shift;
    logic [DATA_W-1:0]      r_rx_data;
    logic                   r_rx_valid;
    logic                   r_busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic                   r_frame_err;
`endif

    // transmit buffer
    logic [DATA_W-1:0]      r_tx_buf;
    logic                   r_tx_full;

    logic                   w_sclk;
    logic                   w_cs;
    logic                   w_mosi;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_consume;
    logic [DATA_W-1:0]      w_tx_next;
    logic [DATA_W-1:0]      w_rx_next;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_dly;
    assign w_sclk_fall = ~w_sclk & r_sclk_dly;
    assign w_cs_fall   = r_warm & ~w_cs & r_cs_dly;
    assign w_cs_rise   = w_cs & ~r_cs_dly;

    // buffer is consumed whenever a word starts: frame start or back-to-back reload
    assign w_consume   = ((r_state == c_ST_IDLE) && w_cs_fall) ||
                         ((r_state == c_ST_COMPLETE) && !w_cs);
    assign w_tx_next   = r_tx_full ? r_tx_buf : '0;
    assign w_rx_next   = {r_rx_shift, w_mosi};

    assign spi_miso    = r_tx_shift[DATA_W-1];
    assign tx_ready    = ~r_tx_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign busy        = r_busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign frame_err   = r_frame_err;
`endif

    // input synchronisers, reset to the bus idle levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_dly  <= 1'b0;
            r_cs_dly    <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], chip_select};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sclk_dly  <= w_sclk;
            r_cs_dly    <= w_cs;
        end
    end

    // hold off frame starts until the chain holds real samples after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_warm_cnt <= '0;
            r_warm     <= 1'b0;
        end else if (!r_warm) begin
            if (r_warm_cnt == c_WARM_CYC) begin
                r_warm <= 1'b1;
            end else begin
                r_warm_cnt <= r_warm_cnt + c_WARM_ONE;
            end
        end
    end

    // one-word transmit buffer; consumption wins over a same-cycle load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_buf  <= '0;
            r_tx_full <= 1'b0;
        end else if (w_consume) begin
            r_tx_full <= 1'b0;
        end else if (tx_load && !r_tx_full) begin
            r_tx_buf  <= tx_data;
            r_tx_full <= 1'b1;
        end
    end

    // frame controller: bit counting, shift registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
            r_rx_valid <= 1'b0;
            r_busy     <= ~w_cs;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            r_frame_err <= 1'b0;
`endif
            if (w_cs) begin
                // deselected: drop any partial word and park MISO low
`ifdef SPI_SLAVE_FRAME_ERR_EN
                if (w_cs_rise && (r_state == c_ST_SHIFT) && (r_bit_cnt != '0)) begin
                    r_frame_err <= 1'b1;
                end
`endif
                r_state    <= c_ST_IDLE;
                r_bit_cnt  <= '0;
                r_tx_shift <= '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_state    <= c_ST_SHIFT;
                            r_bit_cnt  <= '0;
                            r_tx_shift <= w_tx_next;
                        end
                    end
                    c_ST_SHIFT: begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= w_rx_next[DATA_W-2:0];
                            if (r_bit_cnt == c_LAST_BIT) begin
                                r_bit_cnt  <= '0;
                                r_rx_data  <= w_rx_next;
                                r_rx_valid <= 1'b1;
                                r_state    <= c_ST_COMPLETE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
                            end
                        end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
                            // a fall with no bit sampled yet is the trailing edge
                            // of the previous word and must not disturb the new MSB
                            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                    c_ST_COMPLETE: begin
                        r_state    <= c_ST_SHIFT;
                        r_bit_cnt  <= '0;
                        r_tx_shift <= w_tx_next;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave
//  Description : Self-checking bench for spi_slave. Drives SPI mode-0 frames
//                and compares against a word-level model of the transmit
//                buffer and received-word stream. Honours SPI_SLAVE_FRAME_ERR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int HP = 6;   // SPI half-period in clk cycles

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_clk;
    logic       chip_select;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic       frame_err;
    int         n_ferr = 0;
`endif

    int         n_pass  = 0;
    int         n_total = 0;
    int         n_fail  = 0;
    int         n_rx    = 0;
    logic [7:0] rx_q[$];

    // word-level model of the transmit buffer
    bit         model_full = 1'b0;
    logic [7:0] model_buf  = 8'h00;

    always #5 clk = ~clk;

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_clk    (spi_clk),
        .chip_select(chip_select),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
`ifdef SPI_SLAVE_FRAME_ERR_EN
        .frame_err  (frame_err),
`endif
        .busy       (busy)
    );

    // collect every received word as it is announced
    always @(negedge clk) begin
        if (rx_valid) begin
            n_rx++;
            rx_q.push_back(rx_data);
        end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (frame_err) n_ferr++;
`endif
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        if (!model_full) begin
            model_full = 1'b1;
            model_buf  = v;
        end
    endtask

    // value the slave must put on MISO for a word that starts now
    function automatic logic [7:0] take_tx();
        logic [7:0] v;
        v = model_full ? model_buf : 8'h00;
        model_full = 1'b0;
        return v;
    endfunction

    task automatic begin_frame();
        chip_select = 1'b0;
        tick(2 * HP);
    endtask

    task automatic end_frame();
        tick(HP);
        chip_select = 1'b1;
        tick(4 * HP);
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, input bit mid_load,
                        input logic [7:0] mid_v, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[7-i];
            tick(HP);
            spi_clk  = 1'b1;
            mi[7-i]  = spi_miso;
            tick(HP);
            spi_clk  = 1'b0;
            if (mid_load && i == 3) begin
                check("mid_ready_before", {31'd0, tx_ready}, 32'd1);
                load(mid_v);
                check("mid_ready_after", {31'd0, tx_ready}, 32'd0);
            end
        end
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] mi2;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [7:0] mo;
        logic [7:0] saved;
        logic [7:0] exp_words[$];
        int         rx0;
        int         nw;

        reset = 1'b1; spi_clk = 1'b0; chip_select = 1'b1; spi_mosi = 1'b0;
        tx_data = 8'h00; tx_load = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(6);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data",  {24'd0, rx_data},  32'h00);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_miso",     {31'd0, spi_miso}, 32'd0);

        // single word: master sends A5, slave returns 3C
        load(8'h3C);
        check("a5_ready_low", {31'd0, tx_ready}, 32'd0);
        rx_q.delete(); rx0 = n_rx;
        begin_frame();
        check("a5_busy", {31'd0, busy}, 32'd1);
        exp_a = take_tx();
        xfer(8'hA5, 8, 1'b0, 8'h00, mi);
        end_frame();
        check("a5_miso",    {24'd0, mi},      {24'd0, exp_a});
        check("a5_miso_3c", {24'd0, mi},      32'h3C);
        check("a5_rx_cnt",  n_rx - rx0,       32'd1);
        check("a5_rx_data", {24'd0, rx_data}, 32'hA5);
        check("a5_ready",   {31'd0, tx_ready}, 32'd1);
        check("a5_idle",    {31'd0, busy},    32'd0);

        // no buffer load: MISO returns zero, tx_ready stays high
        rx_q.delete(); rx0 = n_rx;
        begin_frame();
        exp_a = take_tx();
        xfer(8'h5E, 8, 1'b0, 8'h00, mi);
        check("empty_ready_mid", {31'd0, tx_ready}, 32'd1);
        end_frame();
        check("empty_miso", {24'd0, mi}, {24'd0, exp_a});
        check("empty_miso0", {24'd0, mi}, 32'h00);
        check("empty_rx", {24'd0, rx_data}, 32'h5E);

        // back-to-back words with a buffer reload during the first
        load(8'h9A);
        rx_q.delete(); rx0 = n_rx;
        begin_frame();
        exp_a = take_tx();
        xfer(8'h12, 8, 1'b1, 8'h56, mi);
        exp_b = take_tx();
        xfer(8'h34, 8, 1'b0, 8'h00, mi2);
        end_frame();
        check("b2b_rx_cnt", n_rx - rx0, 32'd2);
        check("b2b_miso1", {24'd0, mi},  {24'd0, exp_a});
        check("b2b_miso2", {24'd0, mi2}, 32'h56);
        check("b2b_rx1", (rx_q.size() > 0) ? {24'd0, rx_q[0]} : 32'hFFFF, 32'h12);
        check("b2b_rx2", (rx_q.size() > 1) ? {24'd0, rx_q[1]} : 32'hFFFF, 32'h34);
        check("b2b_ready", {31'd0, tx_ready}, 32'd1);

        // second load while the buffer is full is ignored
        load(8'h11);
        check("dbl_ready0", {31'd0, tx_ready}, 32'd0);
        load(8'h22);
        check("dbl_ready1", {31'd0, tx_ready}, 32'd0);
        begin_frame();
        exp_a = take_tx();
        xfer(8'hC3, 8, 1'b0, 8'h00, mi);
        end_frame();
        check("dbl_miso", {24'd0, mi}, 32'h11);
        check("dbl_model", {24'd0, mi}, {24'd0, exp_a});
        begin_frame();
        exp_a = take_tx();
        xfer(8'h3C, 8, 1'b0, 8'h00, mi);
        end_frame();
        check("dbl_after", {24'd0, mi}, 32'h00);

        // chip_select raised after 5 bits
        saved = rx_data; rx0 = n_rx;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        n_ferr = 0;
`endif
        begin_frame();
        exp_a = take_tx();
        xfer(8'($urandom), 5, 1'b0, 8'h00, mi);
        end_frame();
        check("part_rx_cnt", n_rx - rx0, 32'd0);
        check("part_rx_hold", {24'd0, rx_data}, {24'd0, saved});
        check("part_idle", {31'd0, busy}, 32'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("part_ferr", n_ferr, 32'd1);
`endif

        // reset mid-transfer, then a clean word
        begin_frame();
        exp_a = take_tx();
        xfer(8'hFF, 3, 1'b0, 8'h00, mi);
        load(8'h77);
        check("mrst_loaded", {31'd0, tx_ready}, 32'd0);
        reset = 1'b1;
        tick(1);
        check("mrst_ready",   {31'd0, tx_ready}, 32'd1);
        check("mrst_rx_data", {24'd0, rx_data},  32'h00);
        check("mrst_busy",    {31'd0, busy},     32'd0);
        check("mrst_miso",    {31'd0, spi_miso}, 32'd0);
        chip_select = 1'b1; spi_clk = 1'b0;
        model_full = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(10);
        rx0 = n_rx;
        begin_frame();
        exp_a = take_tx();
        xfer(8'h81, 8, 1'b0, 8'h00, mi);
        end_frame();
        check("mrst_rx_cnt", n_rx - rx0, 32'd1);
        check("mrst_rx",     {24'd0, rx_data}, 32'h81);
        check("mrst_miso0",  {24'd0, mi}, {24'd0, exp_a});

        // randomized frames of 1..3 words against the model
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 1) == 1) load(8'($urandom));
            check("rnd_ready_pre", {31'd0, tx_ready}, {31'd0, !model_full});
            nw = $urandom_range(1, 3);
            rx_q.delete(); exp_words.delete(); rx0 = n_rx;
            begin_frame();
            for (int w = 0; w < nw; w++) begin
                exp_a = take_tx();
                mo = 8'($urandom);
                exp_words.push_back(mo);
                xfer(mo, 8, 1'b0, 8'h00, mi);
                check("rnd_miso", {24'd0, mi}, {24'd0, exp_a});
            end
            end_frame();
            check("rnd_rx_cnt", n_rx - rx0, nw);
            for (int w = 0; w < nw; w++) begin
                check("rnd_rx_word", (rx_q.size() > w) ? {24'd0, rx_q[w]} : 32'hFFFF,
                      {24'd0, exp_words[w]});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
